// File: rtl/mod_addsub_pipe_pkg.sv
// rtl/mod_addsub_pipe_pkg.sv - shared curve parameters, op encodings and limb helper
// Purpose: curve-wide constants (field width, prime) plus the modular
//          add/sub op encoding and the limb-count helper used by the
//          limb-pipelined modular adder.
package elliptic_curve_structs;

  localparam int P_WIDTH = 256;

  typedef struct packed {
    logic [P_WIDTH-1:0] p;
  } curve_params_t;

  // secp256k1 field prime
  localparam curve_params_t params = '{
    p: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
  };

  typedef enum logic [1:0] {
    MOD_ADD = 2'd0,
    MOD_SUB = 2'd1,
    MOD_NEG = 2'd2,
    MOD_DBL = 2'd3
  } mod_op_t;

  // Number of LIMB-bit slices needed to cover WIDTH bits (top slice may be narrower).
  function automatic int calc_nlimb(input int width, input int limb);
    return (width + limb - 1) / limb;
  endfunction

endpackage

// File: rtl/mod_addsub_pipe_limb.sv
// rtl/mod_addsub_pipe_limb.sv - one limb of the primary and correction chains
// Purpose: combinational slice of both carry chains for one limb.
// Ports:
//   x, y, p  : operand limbs and modulus limb
//   is_sub   : 1 = subtract path (d = x - y, u = d + P), 0 = add path (s = x + y, t = s - P)
//   pc_in    : primary carry (add) / borrow (sub) from the limb below
//   cc_in    : correction borrow (add) / carry (sub) from the limb below
//   pr, cr   : primary and correction result limbs
//   pc_out, cc_out : carry/borrow out of each chain
module mod_limb_stage #(
  parameter int LW = 64
) (
  input  logic [LW-1:0] x,
  input  logic [LW-1:0] y,
  input  logic [LW-1:0] p,
  input  logic          is_sub,
  input  logic          pc_in,
  input  logic          cc_in,
  output logic [LW-1:0] pr,
  output logic [LW-1:0] cr,
  output logic          pc_out,
  output logic          cc_out
);

  logic [LW:0] prim;
  logic [LW:0] corr;

  // In subtract mode the top bit of the (LW+1)-bit difference is the borrow,
  // since a negative result wraps to >= 2^LW.
  always_comb begin
    prim = '0;
    corr = '0;
    if (is_sub) begin
      prim = {1'b0, x} - {1'b0, y} - {{LW{1'b0}}, pc_in};
      corr = {1'b0, prim[LW-1:0]} + {1'b0, p} + {{LW{1'b0}}, cc_in};
    end else begin
      prim = {1'b0, x} + {1'b0, y} + {{LW{1'b0}}, pc_in};
      corr = {1'b0, prim[LW-1:0]} - {1'b0, p} - {{LW{1'b0}}, cc_in};
    end
  end

  assign pr     = prim[LW-1:0];
  assign pc_out = prim[LW];
  assign cr     = corr[LW-1:0];
  assign cc_out = corr[LW];

endmodule

// File: rtl/mod_addsub_pipe.sv
// rtl/mod_addsub_pipe.sv - limb-pipelined modular add/sub/neg/dbl with valid/ready
// Purpose: computes (a op b) mod P with the carry chains split into LIMB-bit
//          slices, one slice per pipeline stage; one result per cycle.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake
//   in_a, in_b, in_op    : operands and mod_op_t operation
//   in_tag               : sideband returned with the result
//   out_valid/out_ready  : result handshake
//   out_sum, out_tag     : result and its tag
// Ranks: entry register, then one rank per limb, then the output select rank,
// so a result leaves NLIMB+1 edges after its accept edge.
module mod_addsub_pipe
  import elliptic_curve_structs::*;
#(
  parameter int               WIDTH = P_WIDTH,
  parameter logic [WIDTH-1:0] P     = params.p,
  parameter int               LIMB  = 64,
  parameter int               TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  mod_op_t          in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NLIMB = calc_nlimb(WIDTH, LIMB);

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Entry operand mapping
  logic             ent_sub;
  logic [WIDTH-1:0] ent_x;
  logic [WIDTH-1:0] ent_y;

  always_comb begin
    ent_sub = (in_op == MOD_SUB) || (in_op == MOD_NEG);
    ent_x   = (in_op == MOD_NEG) ? '0 : in_a;
    ent_y   = ((in_op == MOD_ADD) || (in_op == MOD_SUB)) ? in_b : in_a;
  end

  // Rank 0 is the entry register; rank k (1..NLIMB) holds limbs 0..k-1 done.
  logic             r_v   [0:NLIMB];
  logic [TAG_W-1:0] r_tag [0:NLIMB];
  logic             r_sub [0:NLIMB];
  logic [WIDTH-1:0] r_x   [0:NLIMB-1];
  logic [WIDTH-1:0] r_y   [0:NLIMB-1];
  logic [WIDTH-1:0] r_pr  [1:NLIMB];
  logic [WIDTH-1:0] r_cr  [1:NLIMB];
  logic             r_pc  [1:NLIMB];
  logic             r_cc  [1:NLIMB];

  logic [WIDTH-1:0] nx_pr [0:NLIMB-1];
  logic [WIDTH-1:0] nx_cr [0:NLIMB-1];
  logic             nx_pc [0:NLIMB-1];
  logic             nx_cc [0:NLIMB-1];

  for (genvar k = 0; k < NLIMB; k++) begin : g_stage
    localparam int LO = k * LIMB;
    localparam int LW = ((WIDTH - LO) < LIMB) ? (WIDTH - LO) : LIMB;

    logic             pc_i;
    logic             cc_i;
    logic [WIDTH-1:0] pr_base;
    logic [WIDTH-1:0] cr_base;
    logic [LW-1:0]    lpr;
    logic [LW-1:0]    lcr;
    logic             lpc;
    logic             lcc;
    logic [WIDTH-1:0] npr;
    logic [WIDTH-1:0] ncr;

    if (k == 0) begin : g_first
      assign pc_i    = 1'b0;
      assign cc_i    = 1'b0;
      assign pr_base = '0;
      assign cr_base = '0;
    end else begin : g_rest
      assign pc_i    = r_pc[k];
      assign cc_i    = r_cc[k];
      assign pr_base = r_pr[k];
      assign cr_base = r_cr[k];
    end

    mod_limb_stage #(.LW(LW)) u_limb (
      .x      (r_x[k][LO +: LW]),
      .y      (r_y[k][LO +: LW]),
      .p      (P[LO +: LW]),
      .is_sub (r_sub[k]),
      .pc_in  (pc_i),
      .cc_in  (cc_i),
      .pr     (lpr),
      .cr     (lcr),
      .pc_out (lpc),
      .cc_out (lcc)
    );

    // Completed lower limbs ride along; this stage fills in its own slice.
    always_comb begin
      npr = pr_base;
      ncr = cr_base;
      npr[LO +: LW] = lpr;
      ncr[LO +: LW] = lcr;
    end

    assign nx_pr[k] = npr;
    assign nx_cr[k] = ncr;
    assign nx_pc[k] = lpc;
    assign nx_cc[k] = lcc;
  end

  // Add: correct when s overflowed WIDTH or s - P did not borrow.
  // Sub: correct (add P back) when x - y borrowed.
  logic fin_corr;
  assign fin_corr = r_sub[NLIMB] ? r_pc[NLIMB] : (r_pc[NLIMB] | ~r_cc[NLIMB]);

  // Datapath ranks carry no reset; their valids below gate them.
  always_ff @(posedge clk) begin
    if (en) begin
      r_tag[0] <= in_tag;
      r_sub[0] <= ent_sub;
      r_x[0]   <= ent_x;
      r_y[0]   <= ent_y;
      for (int k = 0; k < NLIMB; k++) begin
        r_tag[k+1] <= r_tag[k];
        r_sub[k+1] <= r_sub[k];
        r_pr[k+1]  <= nx_pr[k];
        r_cr[k+1]  <= nx_cr[k];
        r_pc[k+1]  <= nx_pc[k];
        r_cc[k+1]  <= nx_cc[k];
      end
      for (int k = 0; k < NLIMB - 1; k++) begin
        r_x[k+1] <= r_x[k];
        r_y[k+1] <= r_y[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= NLIMB; k++) begin
        r_v[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= '0;
    end else if (en) begin
      r_v[0] <= in_valid;
      for (int k = 0; k < NLIMB; k++) begin
        r_v[k+1] <= r_v[k];
      end
      out_valid <= r_v[NLIMB];
      out_sum   <= fin_corr ? r_cr[NLIMB] : r_pr[NLIMB];
      out_tag   <= r_tag[NLIMB];
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb/tb_mod_addsub_pipe.sv - self-checking bench for mod_addsub_pipe
module tb_mod_addsub_pipe;
  import elliptic_curve_structs::*;

  localparam int W  = 8;
  localparam int PM = 97;
  localparam logic [P_WIDTH-1:0] PV = params.p;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Small instance
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  mod_op_t       in_op;
  logic [3:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [3:0]    out_tag;

  // Default instance
  logic               d_in_valid;
  logic               d_in_ready;
  logic [P_WIDTH-1:0] d_in_a;
  logic [P_WIDTH-1:0] d_in_b;
  mod_op_t            d_in_op;
  logic [3:0]         d_in_tag;
  logic               d_out_valid;
  logic               d_out_ready;
  logic [P_WIDTH-1:0] d_out_sum;
  logic [3:0]         d_out_tag;

  mod_addsub_pipe #(.WIDTH(W), .P(8'd97), .LIMB(3), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_tag(out_tag)
  );

  mod_addsub_pipe dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_a(d_in_a), .in_b(d_in_b), .in_op(d_in_op), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_sum(d_out_sum), .out_tag(d_out_tag)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_sum_q [$];
  logic [3:0]   exp_tag_q [$];
  logic [W-1:0] got_sum_q [$];
  logic [3:0]   got_tag_q [$];
  int           out_cyc_q [$];

  task automatic chk(input string name, input logic [P_WIDTH-1:0] got, input logic [P_WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the operation definitions.
  function automatic logic [W-1:0] ref_mod(input int a, input int b, input int op);
    int x, y, r;
    x = (op == 2) ? 0 : a;
    y = (op == 0 || op == 1) ? b : a;
    if (op == 0 || op == 3) begin
      r = x + y;
      if (r >= PM) r = r - PM;
    end else begin
      r = x - y;
      if (r < 0) r = r + PM;
    end
    return W'(r & 255);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process
  logic         held;
  logic [W-1:0] prev_sum;
  logic [3:0]   prev_tag;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_sum", out_sum, prev_sum);
        chk("hold_tag", out_tag, prev_tag);
      end
      if (in_valid && in_ready) begin
        exp_sum_q.push_back(ref_mod(int'(in_a), int'(in_b), int'(in_op)));
        exp_tag_q.push_back(in_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_sum_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result got_sum=%0d got_tag=%0d exp=none", out_sum, out_tag);
        end else begin
          chk("result_sum", out_sum, exp_sum_q.pop_front());
          chk("result_tag", out_tag, exp_tag_q.pop_front());
        end
        got_sum_q.push_back(out_sum);
        got_tag_q.push_back(out_tag);
        out_cyc_q.push_back(cyc);
      end
      held     = out_valid && !out_ready;
      prev_sum = out_sum;
      prev_tag = out_tag;
    end
  end

  task automatic send(input int a, input int b, input int op, input int tag);
    int n;
    in_a     = W'(a);
    in_b     = W'(b);
    in_op    = mod_op_t'(op[1:0]);
    in_tag   = 4'(tag);
    in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=in_ready0 exp=in_ready1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_sum_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_sum_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, a, b, op, n, seen;
    logic [P_WIDTH-1:0] d_got [$];

    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = MOD_ADD; in_tag = '0;
    out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_in_op = MOD_ADD; d_in_tag = '0;
    d_out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model with hand-computed values
    chk("model_add_wrap", ref_mod(96, 1, 0), 0);
    chk("model_sub_neg", ref_mod(5, 10, 1), 92);
    chk("model_neg1", ref_mod(1, 0, 2), 96);
    chk("model_dbl", ref_mod(96, 0, 3), 95);

    // Directed adds, latency and ordering
    got_sum_q.delete(); got_tag_q.delete();
    send(96, 1, 0, 1);
    send(50, 40, 0, 2);
    send(60, 60, 0, 3);
    in_valid = 1'b0;
    chk("lat_n+2", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_n+3", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_n+4", out_valid, 1);
    drain();
    chk("add_count", got_sum_q.size(), 3);
    if (got_sum_q.size() == 3) begin
      chk("add_96_1", got_sum_q[0], 0);
      chk("add_50_40", got_sum_q[1], 90);
      chk("add_60_60", got_sum_q[2], 23);
      chk("tag_1", got_tag_q[0], 1);
      chk("tag_2", got_tag_q[1], 2);
      chk("tag_3", got_tag_q[2], 3);
    end

    // Directed sub/neg/dbl
    got_sum_q.delete(); got_tag_q.delete();
    send(5, 10, 1, 4);
    send(10, 5, 1, 5);
    send(0, 77, 2, 6);
    send(1, 33, 2, 7);
    send(96, 12, 3, 8);
    drain();
    chk("sub_count", got_sum_q.size(), 5);
    if (got_sum_q.size() == 5) begin
      chk("sub_5_10", got_sum_q[0], 92);
      chk("sub_10_5", got_sum_q[1], 5);
      chk("neg_0", got_sum_q[2], 0);
      chk("neg_1", got_sum_q[3], 96);
      chk("dbl_96", got_sum_q[4], 95);
    end

    // Back-to-back random stream
    out_cyc_q.delete();
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 96));
      b  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 96));
      op = int'($urandom_range(0, 3));
      send(a, b, op, i);
    end
    chk("stream_accept_cycles", cyc - t0, 20);
    drain();
    chk("stream_count", out_cyc_q.size(), 20);
    if (out_cyc_q.size() == 20)
      chk("stream_one_per_cycle", out_cyc_q[19] - out_cyc_q[0], 19);

    // Backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          a  = int'($urandom_range(0, 96));
          b  = int'($urandom_range(0, 96));
          op = int'($urandom_range(0, 3));
          send(a, b, op, i + 3);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready_drop", in_ready, 0);
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with operations in flight
    send(10, 20, 0, 9);
    send(30, 40, 1, 10);
    send(50, 0, 3, 11);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_sum_q.delete(); exp_tag_q.delete();
    #1;
    chk("rst_flight_out_valid", out_valid, 0);
    chk("rst_flight_out_sum", out_sum, 0);
    chk("rst_flight_out_tag", out_tag, 0);
    chk("rst_flight_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("rst_no_ghost", seen, 0);

    // Default instance
    @(posedge clk); #1;
    d_in_valid = 1'b1; d_in_op = MOD_ADD; d_in_a = PV - 1; d_in_b = PV - 1; d_in_tag = 4'd5;
    @(posedge clk); #1;
    d_in_op = MOD_SUB; d_in_a = '0; d_in_b = 256'd1; d_in_tag = 4'd6;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    n = 0;
    while (d_got.size() < 2 && n < 30) begin
      @(negedge clk);
      if (d_out_valid) d_got.push_back(d_out_sum);
      n++;
    end
    chk("dflt_count", d_got.size(), 2);
    if (d_got.size() == 2) begin
      chk("dflt_add_pm1_pm1", d_got[0], PV - 2);
      chk("dflt_sub_0_1", d_got[1], PV - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
